// File: rtl/lr_serializer_if.sv
// -----------------------------------------------------------------------------
// lr_serializer_if : word-load / serial-bit handshake bundle for lr_serializer
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface lr_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             direction;
  logic             shift_en;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output load, data, direction, shift_en,
    input  ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  load, data, direction, shift_en,
    output ready, sout, sout_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/lr_serializer.sv
// -----------------------------------------------------------------------------
// lr_serializer : parallel-to-serial shifter, LSB- or MSB-first per word
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module lr_serializer #(
  parameter int WIDTH = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  lr_serializer_if.slave bus
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sreg;
  logic [c_CW-1:0]  r_cnt;
  logic             r_dir;
  logic             r_done;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_sout;
  logic             w_valid;

  // Last bit leaves on this edge; the slot is free for a new word with no bubble
  assign w_last   = (r_state == S_SHIFT) && bus.shift_en && (r_cnt == c_LAST);
  assign w_ready  = reset && ((r_state == S_IDLE) || w_last);
  assign w_accept = bus.load && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_sout  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_valid = 1'b1;
        w_sout  = r_dir ? r_sreg[WIDTH-1] : r_sreg[0];
        if (w_last && !w_accept) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sreg <= bus.data;
        r_dir  <= bus.direction;
        r_cnt  <= '0;
      end else if ((r_state == S_SHIFT) && bus.shift_en) begin
        if (w_last) begin
          r_sreg <= '0;
          r_cnt  <= '0;
        end else begin
          r_sreg <= r_dir ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.ready      = w_ready;
  assign bus.sout       = w_sout;
  assign bus.sout_valid = w_valid;
  assign bus.busy       = w_valid;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lr_serializer.sv
// -----------------------------------------------------------------------------
// tb_lr_serializer : scoreboard bench for lr_serializer (WIDTH = 4)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_lr_serializer;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic b;
    logic last;
  } sb_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_count;
  logic prev_last;
  sb_t  sb[$];

  lr_serializer_if #(.WIDTH(WIDTH)) bus ();

  lr_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bit order derived from the word and direction, independent of the shifter
  task automatic push_word(input logic [WIDTH-1:0] d, input logic dir);
    sb_t e;
    for (int i = 0; i < WIDTH; i++) begin
      e.b    = dir ? d[WIDTH-1-i] : d[i];
      e.last = (i == WIDTH - 1);
      sb.push_back(e);
    end
  endtask

  // Each consumed bit is compared to the scoreboard; done must follow the last bit by one cycle
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      prev_last = 1'b0;
    end else begin
      checks++;
      if (bus.done !== prev_last) begin
        errors++;
        $display("FAIL done_timing got %b exp %b at %0t", bus.done, prev_last, $time);
      end
      if (bus.done === 1'b1) done_count++;
      prev_last = 1'b0;
      if (bus.sout_valid === 1'b1 && bus.shift_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit got %b exp none at %0t", bus.sout, $time);
        end else begin
          e = sb.pop_front();
          if (bus.sout !== e.b) begin
            errors++;
            $display("FAIL sout_bit got %b exp %b at %0t", bus.sout, e.b, $time);
          end
          prev_last = e.last;
        end
      end
    end
  end

  task automatic send_word(input logic [WIDTH-1:0] d, input logic dir);
    bit ok;
    ok = 1'b0;
    bus.load      = 1'b1;
    bus.data      = d;
    bus.direction = dir;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        push_word(d, dir);
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got ready=0 exp ready=1");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL idle_drain got busy=%b left=%0d exp busy=0 left=0", bus.busy, sb.size());
    end
  endtask

  task automatic check_done(input int base, input int n, input string name);
    checks++;
    if (done_count - base != n) begin
      errors++;
      $display("FAIL %s got %0d done pulses exp %0d", name, done_count - base, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ready, bus.sout, bus.sout_valid, bus.busy, bus.done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 00000",
               {bus.ready, bus.sout, bus.sout_valid, bus.busy, bus.done});
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got ready=%b busy=%b exp ready=1 busy=0", bus.ready, bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsb_first();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b0);
    checks++;
    if (bus.sout_valid !== 1'b1 || bus.sout !== 1'b1) begin
      errors++;
      $display("FAIL first_bit_latency got valid=%b sout=%b exp 1 1", bus.sout_valid, bus.sout);
    end
    wait_idle();
    check_done(base, 1, "lsb_done");
  endtask

  task automatic test_msb_first();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b1);
    wait_idle();
    check_done(base, 1, "msb_done");
  endtask

  task automatic test_stall();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b0);
    @(posedge clk);
    #1;
    bus.shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.sout !== 1'b1 || bus.sout_valid !== 1'b1 || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got sout=%b valid=%b ready=%b exp 1 1 0",
                 bus.sout, bus.sout_valid, bus.ready);
      end
    end
    @(posedge clk);
    #1;
    bus.shift_en = 1'b1;
    wait_idle();
    check_done(base, 1, "stall_done");
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b0);
    send_word(4'b0110, 1'b1);
    checks++;
    if (bus.sout_valid !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL no_bubble got valid=%b busy=%b exp 1 1", bus.sout_valid, bus.busy);
    end
    wait_idle();
    check_done(base, 2, "b2b_done");
  endtask

  task automatic test_ignored_load();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b0);
    bus.load      = 1'b1;
    bus.data      = 4'b1111;
    bus.direction = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready got %b exp 0 (cycle %0d)", bus.ready, i);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL last_bit_ready got %b exp 1", bus.ready);
    end
    push_word(4'b1111, 1'b0);
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    wait_idle();
    check_done(base, 2, "held_word_done");
  endtask

  task automatic test_reset_midframe();
    int base;
    base = done_count;
    send_word(4'b1011, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.sout, bus.sout_valid, bus.busy, bus.done} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got %b exp 00000",
               {bus.ready, bus.sout, bus.sout_valid, bus.busy, bus.done});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    check_done(base, 0, "reset_no_done");
    @(posedge clk);
    #1;
    reset = 1'b1;
    base  = done_count;
    send_word(4'b0110, 1'b1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_accept got busy=%b exp 1", bus.busy);
    end
    wait_idle();
    check_done(base, 1, "after_reset_done");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    done_count    = 0;
    prev_last     = 1'b0;
    reset         = 1'b0;
    bus.load      = 1'b0;
    bus.data      = '0;
    bus.direction = 1'b0;
    bus.shift_en  = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_ignored_load();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
